// File: rtl/fpga_test_seq_if.sv
// Bundle between the test sequencer and its board-side environment:
// pushbutton, DUT/ROM result bytes, index and status outputs.
interface fpga_test_seq_if;
    logic       start;
    logic [7:0] out_test;
    logic [7:0] out_truth;
    logic [2:0] test_i;
    logic [7:0] led;
    logic       busy;
    logic       done;
    logic       all_pass;
    logic [3:0] fail_count;

    modport slave (
        input  start,
        input  out_test,
        input  out_truth,
        output test_i,
        output led,
        output busy,
        output done,
        output all_pass,
        output fail_count
    );

    modport master (
        output start,
        output out_test,
        output out_truth,
        input  test_i,
        input  led,
        input  busy,
        input  done,
        input  all_pass,
        input  fail_count
    );
endinterface

// File: rtl/fpga_test_seq.sv
// On-board test sequencer: steps a vector index, waits for the DUT to
// settle, compares DUT output against the ROM and latches per-test results.
module fpga_test_seq #(
    parameter int N_TESTS       = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    fpga_test_seq_if.slave bus
);

    localparam logic [2:0] LAST_IDX = 3'(N_TESTS - 1);
    localparam logic [3:0] SET_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] FAIL_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    state_e     state_q;
    logic       sync1_q;
    logic       sync2_q;
    logic       sync3_q;
    logic [2:0] test_q;
    logic [3:0] cnt_q;
    logic [7:0] led_q;
    logic [3:0] fail_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic       start_edge;
    logic       match;
    logic [3:0] fail_d;

    // Pushbutton is asynchronous: two flops for metastability, third for edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.start;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign start_edge = sync2_q & ~sync3_q;
    assign match      = (bus.out_test == bus.out_truth);
    assign fail_d     = (!match && fail_q != FAIL_MAX) ? fail_q + 4'd1
                                                       : fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            test_q  <= 3'd0;
            cnt_q   <= 4'd0;
            led_q   <= 8'd0;
            fail_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state_q <= SETTLE;
                        test_q  <= 3'd0;
                        cnt_q   <= SET_INIT;
                        led_q   <= 8'd0;
                        fail_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CHECK: begin
                    led_q[test_q] <= match;
                    fail_q        <= fail_d;
                    // Verdict uses this cycle's count so the last test is included
                    if (test_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_d == 4'd0);
                    end else begin
                        state_q <= SETTLE;
                        test_q  <= test_q + 3'd1;
                        cnt_q   <= SET_INIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.test_i     = test_q;
    assign bus.led        = led_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.all_pass   = pass_q;
    assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_fpga_test_seq.sv
// Directed-plus-random bench for the test sequencer; a default instance and
// a 5-test instance share stimulus and are checked against a table model.
module tb_fpga_test_seq;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] truth [8];
    logic [7:0] resp  [8];

    fpga_test_seq_if ifc ();
    fpga_test_seq_if ifc5 ();

    assign ifc.out_truth  = truth[ifc.test_i];
    assign ifc.out_test   = resp[ifc.test_i];
    assign ifc5.start     = ifc.start;
    assign ifc5.out_truth = truth[ifc5.test_i];
    assign ifc5.out_test  = resp[ifc5.test_i];

    fpga_test_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    fpga_test_seq #(.N_TESTS(5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (ifc5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected results straight from the vector tables
    function automatic logic [7:0] exp_led(input int n);
        logic [7:0] r = 8'd0;
        for (int k = 0; k < n; k++) r[k] = (resp[k] == truth[k]);
        return r;
    endfunction

    function automatic int exp_fail(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (resp[k] != truth[k]) c++;
        return (c > 8) ? 8 : c;
    endfunction

    task automatic load(input logic [7:0] match_mask);
        for (int k = 0; k < 8; k++) begin
            truth[k] = 8'($urandom_range(0, 255));
            resp[k]  = match_mask[k] ? truth[k]
                                     : truth[k] ^ 8'($urandom_range(1, 255));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start high, waits for the pass and checks length, step timing
    // and final result of both instances.  poke_at >= 0 re-pulses start.
    task automatic run_pass(input string tag, input bit drop, input int poke_at);
        int cyc;
        int waited;
        int step_bad;
        int first_step;
        logic [2:0] prev;
        ifc.start = 1'b1;
        waited = 0;
        while (!ifc.busy && waited < 12) begin
            tick();
            waited++;
        end
        if (!ifc.busy) begin
            check({tag, ".busy_rise"}, 0, 1);
            ifc.start = 1'b0;
            return;
        end
        if (drop) ifc.start = 1'b0;
        cyc = 0;
        step_bad = 0;
        first_step = -1;
        prev = ifc.test_i;
        while (ifc.busy && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == poke_at) ifc.start = 1'b1;
            if (poke_at >= 0 && cyc == poke_at + 3) ifc.start = 1'b0;
            if (ifc.test_i != prev) begin
                if (first_step < 0) first_step = cyc;
                if (cyc != 5 * int'(ifc.test_i)) step_bad++;
                prev = ifc.test_i;
            end
        end
        check({tag, ".len"}, cyc, 40);
        check({tag, ".first_step"}, first_step, 5);
        check({tag, ".step_bad"}, step_bad, 0);
        check({tag, ".done"}, ifc.done, 1);
        check({tag, ".busy"}, ifc.busy, 0);
        check({tag, ".test_i"}, ifc.test_i, 7);
        check({tag, ".led"}, ifc.led, exp_led(8));
        check({tag, ".fail"}, ifc.fail_count, exp_fail(8));
        check({tag, ".all_pass"}, ifc.all_pass, exp_fail(8) == 0);
        check({tag, ".n5.done"}, ifc5.done, 1);
        check({tag, ".n5.test_i"}, ifc5.test_i, 4);
        check({tag, ".n5.led"}, ifc5.led, exp_led(5));
        check({tag, ".n5.fail"}, ifc5.fail_count, exp_fail(5));
        check({tag, ".n5.all_pass"}, ifc5.all_pass, exp_fail(5) == 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, ifc.busy, 0);
        check({tag, ".done"}, ifc.done, 0);
        check({tag, ".all_pass"}, ifc.all_pass, 0);
        check({tag, ".led"}, ifc.led, 0);
        check({tag, ".fail"}, ifc.fail_count, 0);
        check({tag, ".test_i"}, ifc.test_i, 0);
        check({tag, ".n5.busy"}, ifc5.busy, 0);
        check({tag, ".n5.led"}, ifc5.led, 0);
    endtask

    initial begin
        int w;
        logic [7:0] m;
        rst       = 1'b1;
        ifc.start = 1'b0;
        load(8'hFF);
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        repeat (3) tick();

        load(8'hFF);
        run_pass("all_match", 1'b1, -1);
        check("all_match.led_lit", ifc.led, 8'hFF);

        load(8'hF7);
        run_pass("one_fail", 1'b1, -1);
        check("one_fail.led_lit", ifc.led, 8'hF7);

        load(8'($urandom));
        run_pass("restart_busy", 1'b1, 10);

        load(8'h00);
        run_pass("all_miss", 1'b1, -1);
        check("all_miss.fail8", ifc.fail_count, 8);
        load(8'hFF);
        run_pass("rerun", 1'b1, -1);

        load(8'($urandom));
        run_pass("hold", 1'b0, -1);
        repeat (12) tick();
        check("hold.no_rerun_busy", ifc.busy, 0);
        check("hold.no_rerun_done", ifc.done, 1);
        ifc.start = 1'b0;
        repeat (3) tick();

        m = 8'($urandom);
        load(m);
        ifc.start = 1'b1;
        w = 0;
        while (ifc.test_i != 3'd4 && w < 100) begin
            tick();
            w++;
        end
        check("midrst.reach4", ifc.test_i, 4);
        #2 rst = 1'b1;
        #1;
        check_idle("midrst");
        repeat (2) tick();
        #3 rst = 1'b0;
        run_pass("after_rst", 1'b0, -1);
        repeat (12) tick();
        check("after_rst.single", ifc.busy, 0);
        ifc.start = 1'b0;
        repeat (3) tick();

        for (int p = 0; p < 4; p++) begin
            load(8'($urandom));
            run_pass($sformatf("rand%0d", p), 1'b1, -1);
            repeat (2) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
